dmem_split_lsu: RTL and testbench
=================================

// Module: dmem_split_lsu
// PURPOSE
//  Load/store unit between the rv32 memory stage and dmem. Aligned accesses pass straight through in
//  one cycle. Misaligned halfword/word accesses are split into sequential byte accesses; loads are
//  reassembled and extended. A stall holds the pipeline until a split access completes.
// PARAMETERS
//  (none) - data and address width fixed at 32; byte count per split fixed by width (2 or 4).
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  reset          in   1   synchronous, active-high
//  req_valid      in   1   memory-stage op present (load or store)
//  req_we         in   1   1 = store, 0 = load
//  req_addr       in   32  byte address (aluout)
//  req_control    in   3   [2] usignext, [1:0] width: 00 byte, 01 half, 10 word, 11 treated as word
//  req_wdata      in   32  store data, low bytes significant
//  stall          out  1   hold PC/pipeline regs; request inputs must stay stable while high
//  resp_valid     out  1   load data valid this cycle
//  resp_rdata     out  32  extended load result
//  misalign_fault out  1   misaligned access trapped (MISALIGN_TRAP_EN only, else 0)
//  mem_we         out  1   to dmem.we
//  mem_addr       out  32  to dmem.address
//  mem_usignext   out  1   to dmem.usignext
//  mem_width      out  2   to dmem.width
//  mem_wdata      out  32  to dmem.w_data
//  mem_rdata      in   32  from dmem.r_data (combinational read, write at posedge)
// BEHAVIOUR
//  - misaligned = (half & addr[0]) | (word & addr[1:0]!=0); byte never misaligned.
//  - States: IDLE, SPLIT, DONE. Byte counter cnt (2b), byte buffer buf[31:0].
//  - IDLE, aligned or !req_valid: combinational pass-through of we/addr/control/wdata; stall=0;
//    resp_valid = req_valid & !req_we; resp_rdata = mem_rdata. Latency 0 (same cycle).
//  - IDLE, req_valid & misaligned: same cycle issues byte 0 (mem_width=00, mem_usignext=1,
//    mem_addr=req_addr, mem_wdata low byte = req_wdata[7:0]); stall=1; cnt<=1; buf[7:0]<=mem_rdata[7:0];
//    -> SPLIT.
//  - SPLIT: issue byte cnt at req_addr+cnt (32-bit modular, 0xFFFFFFFF+1 wraps to 0), wdata byte
//    = req_wdata[8*cnt+7:8*cnt]; capture mem_rdata[7:0] into buf byte cnt; stall=1.
//    cnt==N-1 (N=2 half, 4 word) -> DONE, else cnt<=cnt+1.
//  - DONE: mem_we=0, stall=0; for loads resp_valid=1, resp_rdata = buf low 16 bits sign/zero
//    extended per usignext (half) or buf (word); -> IDLE. Pipeline advances at this edge.
//  - Cycles stalled: half 2, word 4; result in cycle 3 / 5 counting from request.
//  - Outputs while IDLE with !req_valid: mem_we=0, resp_valid=0, resp_rdata=mem_rdata.
//  - Reset (any state, incl. mid-split): state<=IDLE, cnt<=0, buf<=0; mem_we, stall, resp_valid,
//    misalign_fault forced 0 during the reset cycle. Partial split stores are not rolled back.
//  - req_valid dropping mid-split is illegal (protocol violation); FSM completes regardless.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: no splitting; misaligned request -> misalign_fault=1 same cycle,
//    mem_we=0, resp_valid=0, stall=0, FSM stays IDLE (SPLIT/DONE unreachable).
//  Undefined: split behaviour above; misalign_fault tied 0.
// TESTING
//  1 aligned sw 0xDEADBEEF @0x100 then lw @0x100 -> each 1 cycle, stall never 1, rdata 0xDEADBEEF.
//  2 sw 0x11223344 @0x101 -> stall 4 cycles; bytes 0x44,0x33,0x22,0x11 at 0x101..0x104;
//    aligned lw @0x100/0x104 give 0x223344xx / 0xxxxxxx11.
//  3 bytes 0x80,0xFF at 0x203..0x204; lh @0x203 -> resp 0xFFFFFF80... resp_rdata=0xFFFFFF80
//    wait: value 0xFF80 -> lh 0xFFFFFF80, lhu 0x0000FF80; resp in cycle 3, stall 2 cycles.
//  4 lw @0xFFFFFFFE -> accesses 0xFFFFFFFE,0xFFFFFFFF,0x0,0x1 in order.
//  5 reset asserted in 2nd SPLIT cycle of misaligned sw -> next cycle IDLE, stall=0, mem_we=0;
//    only byte 0 (and byte 1 if its edge preceded reset) written.
//  6 MISALIGN_TRAP_EN: lw @0x102 -> misalign_fault=1 one cycle, mem_we=0, stall=0; lw @0x100 normal.

Source files
------------

// File: rtl/dmem_split_lsu.sv
// Load/store unit between the rv32 memory stage and dmem: aligned accesses pass straight through,
// misaligned half/word accesses become byte sequences. Optional macro: MISALIGN_TRAP_EN (trap instead of split).
module dmem_split_lsu (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_control,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign_fault,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic        mem_usignext,
  output logic [1:0]  mem_width,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is consumed at the first posedge where req_valid=1 and stall=0;
  // while stall=1 the request inputs must hold. resp_valid marks load data on resp_rdata that cycle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPLIT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_nxt;
  logic [31:0] r_buf;
  logic        w_cap_en;
  logic [1:0]  w_cap_lane;

  logic        w_is_half;
  logic        w_is_word;
  logic        w_misaligned;
  logic [1:0]  w_last_cnt;
  logic [4:0]  w_lane_sel;
  logic [31:0] w_half_ext;

  logic        w_mem_we;
  logic        w_stall;
  logic        w_resp_valid;
  logic        w_fault;

  assign w_is_half    = (req_control[1:0] == 2'b01);
  assign w_is_word    = req_control[1];
  assign w_misaligned = (w_is_half & req_addr[0]) | (w_is_word & (req_addr[1:0] != 2'b00));
  assign w_last_cnt   = w_is_word ? 2'd3 : 2'd1;
  assign w_lane_sel   = {r_cnt, 3'b000};
  assign w_half_ext   = req_control[2] ? {16'h0000, r_buf[15:0]}
                                       : {{16{r_buf[15]}}, r_buf[15:0]};

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_cap_en     = 1'b0;
    w_cap_lane   = r_cnt;
    w_mem_we     = 1'b0;
    mem_addr     = req_addr;
    mem_width    = req_control[1:0];
    mem_usignext = req_control[2];
    mem_wdata    = req_wdata;
    w_stall      = 1'b0;
    w_resp_valid = 1'b0;
    resp_rdata   = mem_rdata;
    w_fault      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid && w_misaligned) begin
`ifdef MISALIGN_TRAP_EN
          w_fault = 1'b1;
`else
          // Byte 0 goes out in the request cycle itself, so the split costs only N stalled cycles.
          w_mem_we     = req_we;
          mem_width    = 2'b00;
          mem_usignext = 1'b1;
          mem_wdata    = {24'h000000, req_wdata[7:0]};
          w_stall      = 1'b1;
          w_cap_en     = 1'b1;
          w_cap_lane   = 2'd0;
          w_cnt_nxt    = 2'd1;
          w_state_nxt  = ST_SPLIT;
`endif
        end else begin
          w_mem_we     = req_valid & req_we;
          w_resp_valid = req_valid & ~req_we;
        end
      end
      ST_SPLIT: begin
        w_mem_we     = req_we;
        mem_addr     = req_addr + {30'h0, r_cnt};
        mem_width    = 2'b00;
        mem_usignext = 1'b1;
        mem_wdata    = {24'h000000, req_wdata[w_lane_sel +: 8]};
        w_stall      = 1'b1;
        w_cap_en     = 1'b1;
        if (r_cnt == w_last_cnt) begin
          w_cnt_nxt   = 2'd0;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt   = r_cnt + 2'd1;
        end
      end
      ST_DONE: begin
        w_resp_valid = ~req_we;
        resp_rdata   = w_is_word ? r_buf : w_half_ext;
        w_state_nxt  = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_buf   <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_cap_en) begin
        r_buf[{w_cap_lane, 3'b000} +: 8] <= mem_rdata[7:0];
      end
    end
  end

  // Side-effecting outputs are suppressed during the reset cycle; a partial split store stays written.
  assign mem_we         = w_mem_we & ~reset;
  assign stall          = w_stall & ~reset;
  assign resp_valid     = w_resp_valid & ~reset;
  assign misalign_fault = w_fault & ~reset;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_dmem_split_lsu.sv
// Bench for dmem_split_lsu: byte-array dmem model, directed requests, expected-queue scoreboard.
module tb_dmem_split_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_control;
  logic [31:0] req_wdata;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        misalign_fault;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic        mem_usignext;
  logic [1:0]  mem_width;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  logic [7:0]  mem [0:1023];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [43:0] acc_q[$];

  dmem_split_lsu dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_control(req_control), .req_wdata(req_wdata), .stall(stall), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .misalign_fault(misalign_fault), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_usignext(mem_usignext), .mem_width(mem_width), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // dmem model: combinational little-endian read, write at posedge
  logic [9:0] a0;
  logic [7:0] b0, b1, b2, b3;
  assign a0 = mem_addr[9:0];
  assign b0 = mem[a0];
  assign b1 = mem[a0 + 10'd1];
  assign b2 = mem[a0 + 10'd2];
  assign b3 = mem[a0 + 10'd3];

  always_comb begin
    mem_rdata = {b3, b2, b1, b0};
    case (mem_width)
      2'b00:   mem_rdata = mem_usignext ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'b01:   mem_rdata = mem_usignext ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: mem_rdata = {b3, b2, b1, b0};
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      mem[a0] <= mem_wdata[7:0];
      if (mem_width != 2'b00) mem[a0 + 10'd1] <= mem_wdata[15:8];
      if (mem_width[1]) begin
        mem[a0 + 10'd2] <= mem_wdata[23:16];
        mem[a0 + 10'd3] <= mem_wdata[31:24];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_acc(input logic we, input logic [31:0] addr, input logic [7:0] wbyte);
    acc_q.push_back({we, 2'b00, 1'b1, addr, wbyte});
  endtask

  // scoreboard monitor: every stalled cycle is one byte access, every resp_valid one load result
  always @(negedge clk) begin
    if (!reset) begin
      if (stall) begin
        if (acc_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_split_access: addr %0h we %0b, expected none", mem_addr, mem_we);
        end else begin
          check("split_access", {mem_we, mem_width, mem_usignext, mem_addr, mem_wdata[7:0]},
                acc_q.pop_front());
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_resp: rdata %0h, expected no response", resp_rdata);
        end else begin
          check("resp_rdata", resp_rdata, exp_q.pop_front());
        end
      end
    end
  end

  // driver: hold the request until stall drops, then retire it at the next edge
  task automatic issue(input string name, input logic we, input logic [31:0] addr,
                       input logic [2:0] ctrl, input logic [31:0] wdata, input int exp_stall);
    int n;
    n = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_control = ctrl; req_wdata = wdata;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (!stall) break;
      n++;
    end
    check({name, "_stall_cycles"}, n, exp_stall);
    check({name, "_final_we"}, mem_we, we && (exp_stall == 0));
    check({name, "_fault"}, misalign_fault, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    mem[10'h203] <= 8'h80; mem[10'h204] <= 8'hFF;
    mem[10'h3FE] <= 8'hAA; mem[10'h3FF] <= 8'hBB; mem[10'h000] <= 8'hCC; mem[10'h001] <= 8'hDD;
    mem[10'h300] <= 8'h77;
    for (int i = 10'h301; i <= 10'h304; i++) mem[i] <= 8'h5A;

    // reset with a misaligned store presented: nothing may be driven
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h101;
    req_control = 3'b010; req_wdata = 32'h12345678;
    @(negedge clk);
    check("reset_outputs", {stall, mem_we, resp_valid, misalign_fault}, 4'b0000);
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    @(negedge clk);
    check("post_reset_state", {dbg_state, stall, mem_we, resp_valid}, 5'b00000);
    @(posedge clk); #1;

    // aligned store then load
    issue("sw_aligned", 1'b1, 32'h100, 3'b010, 32'hDEADBEEF, 0);
    exp_q.push_back(32'hDEADBEEF);
    issue("lw_aligned", 1'b0, 32'h100, 3'b010, 32'h0, 0);

    // misaligned word store, then aligned readback
    push_acc(1'b1, 32'h101, 8'h44); push_acc(1'b1, 32'h102, 8'h33);
    push_acc(1'b1, 32'h103, 8'h22); push_acc(1'b1, 32'h104, 8'h11);
    issue("sw_mis", 1'b1, 32'h101, 3'b010, 32'h11223344, 4);
    exp_q.push_back(32'h223344EF);
    issue("lw_100", 1'b0, 32'h100, 3'b010, 32'h0, 0);
    exp_q.push_back(32'h00000011);
    issue("lw_104", 1'b0, 32'h104, 3'b010, 32'h0, 0);

    // misaligned halfword store and aligned half loads
    push_acc(1'b1, 32'h107, 8'hFE); push_acc(1'b1, 32'h108, 8'hCA);
    issue("sh_mis", 1'b1, 32'h107, 3'b001, 32'h0000CAFE, 2);
    exp_q.push_back(32'hFE000011);
    issue("lw_104b", 1'b0, 32'h104, 3'b010, 32'h0, 0);
    exp_q.push_back(32'hFFFFFE00);
    issue("lh_106", 1'b0, 32'h106, 3'b001, 32'h0, 0);
    exp_q.push_back(32'h00002233);
    issue("lhu_102", 1'b0, 32'h102, 3'b101, 32'h0, 0);

    // misaligned half loads with sign / zero extension, plus byte load at odd address
    push_acc(1'b0, 32'h203, 8'h00); push_acc(1'b0, 32'h204, 8'h00);
    exp_q.push_back(32'hFFFFFF80);
    issue("lh_mis", 1'b0, 32'h203, 3'b001, 32'h0, 2);
    push_acc(1'b0, 32'h203, 8'h00); push_acc(1'b0, 32'h204, 8'h00);
    exp_q.push_back(32'h0000FF80);
    issue("lhu_mis", 1'b0, 32'h203, 3'b101, 32'h0, 2);
    exp_q.push_back(32'hFFFFFF80);
    issue("lb_odd", 1'b0, 32'h203, 3'b000, 32'h0, 0);

    // word load wrapping past the top of the address space
    push_acc(1'b0, 32'hFFFFFFFE, 8'h00); push_acc(1'b0, 32'hFFFFFFFF, 8'h00);
    push_acc(1'b0, 32'h00000000, 8'h00); push_acc(1'b0, 32'h00000001, 8'h00);
    exp_q.push_back(32'hDDCCBBAA);
    issue("lw_wrap", 1'b0, 32'hFFFFFFFE, 3'b010, 32'h0, 4);

    // width code 11 behaves as word
    push_acc(1'b0, 32'h102, 8'h00); push_acc(1'b0, 32'h103, 8'h00);
    push_acc(1'b0, 32'h104, 8'h00); push_acc(1'b0, 32'h105, 8'h00);
    exp_q.push_back(32'h00112233);
    issue("lw11_mis", 1'b0, 32'h102, 3'b011, 32'h0, 4);

    // reset during the second SPLIT cycle of a misaligned store
    push_acc(1'b1, 32'h301, 8'hD4); push_acc(1'b1, 32'h302, 8'hC3);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h301; req_control = 3'b010;
    req_wdata = 32'hA1B2C3D4;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midsplit_reset_outputs", {stall, mem_we, resp_valid}, 3'b000);
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    @(negedge clk);
    check("after_midsplit_reset", {dbg_state, stall, mem_we}, 4'b0000);
    @(posedge clk); #1;
    exp_q.push_back(32'h5AC3D477);
    issue("lw_300", 1'b0, 32'h300, 3'b010, 32'h0, 0);
    exp_q.push_back(32'h0000005A);
    issue("lbu_304", 1'b0, 32'h304, 3'b100, 32'h0, 0);

    repeat (3) @(posedge clk);
    #1;
    check("resp_queue_drained", exp_q.size(), 0);
    check("access_queue_drained", acc_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
